// File: rtl/mdu_pipelined.sv
// HI/LO multiply/divide unit: MULT/DIV results commit exactly MULT_CYCLES/DIV_CYCLES edges after issue; MTHI/MTLO take one edge.
// No queueing: start is ignored while busy, so the issuing pipeline must stall on busy.
module mdu_pipelined #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [2:0]       op_q, op_nx;
  logic [WIDTH-1:0] a_q, a_nx, b_q, b_nx, hi_nx, lo_nx;

  // Results are formed from the latched operands and committed on the last RUN edge.
  logic signed [2*WIDTH-1:0] prod_s;
  logic        [2*WIDTH-1:0] prod_u;
  logic                      div_zero, div_ovf;
  logic        [WIDTH-1:0]   div_safe;
  logic signed [WIDTH-1:0]   quot_s, rem_s;
  logic        [WIDTH-1:0]   quot_u, rem_u;

  assign prod_s = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
  assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

  // The overflow case is steered to a harmless divisor and its result forced below.
  assign div_zero = (b_q == '0);
  assign div_ovf  = (a_q == MOST_NEG) && (b_q == '1);
  assign div_safe = (div_zero || div_ovf) ? WIDTH'(1) : b_q;
  assign quot_s   = $signed(a_q) / $signed(div_safe);
  assign rem_s    = $signed(a_q) % $signed(div_safe);
  assign quot_u   = a_q / div_safe;
  assign rem_u    = a_q % div_safe;

  assign busy = (state == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      op_q  <= op_nx;
      a_q   <= a_nx;
      b_q   <= b_nx;
      hi    <= hi_nx;
      lo    <= lo_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    op_nx    = op_q;
    a_nx     = a_q;
    b_nx     = b_q;
    hi_nx    = hi;
    lo_nx    = lo;
    case (state)
      IDLE: begin
        if (start) begin
          case (md_op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              op_nx    = md_op;
              a_nx     = a;
              b_nx     = b;
              cnt_nx   = (md_op == OP_MULT || md_op == OP_MULTU) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
              state_nx = RUN;
            end
            OP_MTHI: hi_nx = a;
            OP_MTLO: lo_nx = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt == CW'(1)) begin
          cnt_nx   = '0;
          state_nx = IDLE;
          case (op_q)
            OP_MULT: begin
              hi_nx = prod_s[2*WIDTH-1:WIDTH];
              lo_nx = prod_s[WIDTH-1:0];
            end
            OP_MULTU: begin
              hi_nx = prod_u[2*WIDTH-1:WIDTH];
              lo_nx = prod_u[WIDTH-1:0];
            end
            OP_DIV: begin
              if (div_ovf) begin
                hi_nx = '0;
                lo_nx = MOST_NEG;
              end else if (!div_zero) begin
                hi_nx = rem_s;
                lo_nx = quot_s;
              end
            end
            OP_DIVU: begin
              if (!div_zero) begin
                hi_nx = rem_u;
                lo_nx = quot_u;
              end
            end
            default: ;
          endcase
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/mdu_pipelined.md
# mdu_pipelined

Parametrised multiply/divide unit with HI/LO registers for the pipelined MIPS core. It sits beside the ALU in the execute stage and runs MULT/MULTU/DIV/DIVU as multi-cycle operations, asserting `busy` so hazard control can stall later HI/LO accesses. MTHI/MTLO write in one cycle. HI and LO are continuously readable for MFHI/MFLO.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width.
- `MULT_CYCLES`, 5, cycles `busy` stays high for MULT/MULTU. Must be ≥ 1.
- `DIV_CYCLES`, 10, cycles `busy` stays high for DIV/DIVU. Must be ≥ 1.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `reset`  in  1  synchronous, active-high. Clears all state.
- `start`  in  1  request. Sampled at the rising edge.
- `md_op`  in  3  operation: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none).
- `a`  in  WIDTH  rs operand (dividend; MTHI/MTLO source).
- `b`  in  WIDTH  rt operand (divisor).
- `busy`  out  1  multi-cycle operation in progress.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- State machine: IDLE and RUN. A down-counter sized to `max(MULT_CYCLES, DIV_CYCLES)` tracks the RUN cycles.
- IDLE, `start`=1, op 1–4:
  - latch `a`, `b` and the op;
  - load the counter with MULT_CYCLES or DIV_CYCLES;
  - go to RUN.
- IDLE, `start`=1, op 5: `hi` <= `a`. `lo` is unchanged. Stay in IDLE.
- IDLE, `start`=1, op 6: `lo` <= `a`. `hi` is unchanged. Stay in IDLE.
- IDLE, `start`=0 or op 0/7: no change.
- RUN: decrement the counter each cycle. When it reaches 1, write the result to `hi`/`lo` and return to IDLE.
- In RUN, `start` is ignored for every op, including MTHI/MTLO. The issuing pipeline must stall; the unit does not queue requests.
- Results are computed from the latched operands only. Changes on `a`/`b` during RUN have no effect.
- MULT: signed 2·WIDTH product. `hi` = upper WIDTH bits, `lo` = lower WIDTH bits.
- MULTU: same split, unsigned product.
- DIV: signed. `lo` = quotient truncated toward zero; `hi` = remainder with the sign of the dividend.
- DIVU: unsigned. `lo` = quotient, `hi` = remainder.
- Divisor 0 (DIV or DIVU): full busy duration, then `hi`/`lo` unchanged.
- DIV with most-negative dividend / −1: `lo` = most-negative value, `hi` = 0.
- The result may be computed combinationally and committed at the final edge, or computed iteratively. Only the commit timing below is observable.

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0, state IDLE, counter 0.
- `start` for op 1–4 sampled at edge T:
  - `busy`=1 from after T through the cycle ending at edge T+N, with N = MULT_CYCLES or DIV_CYCLES;
  - `hi`/`lo` update at edge T+N, the same edge at which `busy` falls.
- `busy` is high for exactly N cycles. A new op may be issued in the first cycle `busy` is low (back-to-back issue at edge T+N+1).
- MTHI/MTLO sampled at edge T: the register holds the new value after T. `busy` never rises.
- `reset` during RUN: at that edge `busy`=0, `hi`=`lo`=0, and the pending result is discarded.
- `reset` and `start` at the same edge: reset wins; nothing is issued.
- `busy` is a registered output with no combinational path from `start`.

## Test plan
- MULT, a=0xFFFFFFFF, b=0x00000002, defaults:
  - `busy` is high exactly 5 cycles;
  - then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE;
  - `hi`/`lo` are unchanged while busy.
- MULTU with the same operands: `hi`=0x00000001, `lo`=0xFFFFFFFE after 5 cycles.
- DIV, a=0xFFFFFFF9 (−7), b=2: after 10 busy cycles `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU, a=7, b=2: `lo`=3, `hi`=1.
- DIV 0x80000000/0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
- Divide by zero:
  - MTHI 0x12345678, then MTLO 0x9ABCDEF0 on consecutive cycles (each visible the next cycle, `busy` stays 0);
  - then DIVU a=5, b=0: `busy` high 10 cycles, `hi`/`lo` keep 0x12345678/0x9ABCDEF0.
- Stall and reset:
  - MULT issued; during busy, `start` with MTLO 0xAAAA and then DIV: both ignored, MULT result committed.
  - Second MULT; `reset` asserted on its 3rd busy cycle: next cycle `busy`=0, `hi`=`lo`=0, and no late write follows.
- Parameter sweep MULT_CYCLES=1, DIV_CYCLES=1:
  - `busy` high exactly one cycle per op;
  - back-to-back MULT, DIVU, MULT issued on every cycle `busy` is low all produce correct results.
